// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: machine word width and the branch target buffer entry layout.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int BTB_CNT_W = 2;

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      tag;
    logic [XLEN-1:0]      target;
    logic [BTB_CNT_W-1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/bpred_sat_cnt.sv
// Next-value logic for one saturating direction counter; init (allocation) wins over inc/dec.
module bpred_sat_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             init_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WEAK_T = {1'b1, {(CNT_W-1){1'b0}}};

  always_comb begin
    cnt_o = cnt_i;
    if (init_i) begin
      cnt_o = CNT_WEAK_T;
    end else if (inc_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + 1'b1;
    end else if (dec_i) begin
      if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Fully associative branch target buffer with per-entry direction counters and a one-cycle lookup.
module bpred_btb
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int CNT_W   = BTB_CNT_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            lkp_v_i,
  input  logic [XLEN-1:0] lkp_pc_i,
  output logic            lkp_v_o,
  output logic            lkp_hit_o,
  output logic            lkp_taken_o,
  output logic [XLEN-1:0] lkp_target_o,
  input  logic            upd_v_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [XLEN-1:0]               tag_q    [ENTRIES];
  logic [XLEN-1:0]               target_q [ENTRIES];
  logic [ENTRIES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]              rr_q, rr_d;

  logic [ENTRIES-1:0] lkp_match, upd_match, upd_sel, alloc_sel;
  logic               lkp_hit, lkp_taken;
  logic [XLEN-1:0]    lkp_target;
  logic               upd_ok, upd_hit, alloc, any_invalid;
  logic [IDX_W-1:0]   victim;

  logic            lkp_v_q, lkp_hit_q, lkp_taken_q;
  logic [XLEN-1:0] lkp_target_q;

  // Allocation only happens on an update miss, so at most one valid entry can ever match a PC.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    assign lkp_match[gi] = valid_q[gi] && (tag_q[gi] == lkp_pc_i);
    assign upd_match[gi] = valid_q[gi] && (tag_q[gi] == upd_pc_i);
    assign upd_sel[gi]   = upd_ok && upd_match[gi];
    assign alloc_sel[gi] = alloc && (victim == IDX_W'(gi));

    bpred_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .inc_i  (upd_sel[gi] && upd_taken_i),
      .dec_i  (upd_sel[gi] && !upd_taken_i),
      .init_i (alloc_sel[gi]),
      .cnt_i  (cnt_q[gi]),
      .cnt_o  (cnt_d[gi])
    );
  end

  always_comb begin
    lkp_hit    = |lkp_match;
    lkp_taken  = 1'b0;
    lkp_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lkp_match[i]) begin
        lkp_taken  = lkp_taken | cnt_q[i][CNT_W-1];
        lkp_target = lkp_target | target_q[i];
      end
    end
  end

  // Lowest-index invalid entry wins; the round-robin pointer is only the fallback.
  always_comb begin
    victim      = rr_q;
    any_invalid = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        victim      = IDX_W'(i);
        any_invalid = 1'b1;
      end
    end
  end

  assign upd_ok  = upd_v_i && !flush_i;
  assign upd_hit = |upd_match;
  assign alloc   = upd_ok && !upd_hit && upd_taken_i;

  always_comb begin
    valid_d = valid_q | alloc_sel;
    rr_d    = rr_q;
    if (alloc && !any_invalid) rr_d = rr_q + 1'b1;
    if (flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
    end
  end

  // Payload needs no reset; writes are still held off during reset so no update leaks through.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      cnt_q <= cnt_d;
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_sel[i]) tag_q[i] <= upd_pc_i;
        if (alloc_sel[i] || (upd_sel[i] && upd_taken_i)) target_q[i] <= upd_target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      lkp_v_q      <= 1'b0;
      lkp_hit_q    <= 1'b0;
      lkp_taken_q  <= 1'b0;
      lkp_target_q <= '0;
    end else begin
      lkp_v_q      <= lkp_v_i;
      lkp_hit_q    <= lkp_v_i && lkp_hit;
      lkp_taken_q  <= lkp_v_i && lkp_taken;
      lkp_target_q <= lkp_v_i ? lkp_target : '0;
    end
  end

  assign lkp_v_o      = lkp_v_q;
  assign lkp_hit_o    = lkp_hit_q;
  assign lkp_taken_o  = lkp_taken_q;
  assign lkp_target_o = lkp_target_q;

endmodule

// File: doc/bpred_btb.md
BPRED_BTB -- requirements
Module: bpred_btb

Interface
REQ-001 Parameter ENTRIES, default 8, number of BTB entries; SHALL be a power of two, >= 2.
REQ-002 Parameter CNT_W, default 2, width of each saturating direction counter; SHALL be >= 2.
REQ-003 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n  in  1  reset, synchronous and active-low.
REQ-005 Port flush_i  in  1  invalidate all entries.
REQ-006 Port lkp_v_i  in  1  lookup request from fetch.
REQ-007 Port lkp_pc_i  in  XLEN  PC to look up.
REQ-008 Port lkp_v_o  out  1  lookup result valid.
REQ-009 Port lkp_hit_o  out  1  looked-up PC present in BTB.
REQ-010 Port lkp_taken_o  out  1  predicted taken.
REQ-011 Port lkp_target_o  out  XLEN  predicted target.
REQ-012 Port upd_v_i  in  1  resolved-branch update from branch unit.
REQ-013 Port upd_pc_i  in  XLEN  resolved branch PC.
REQ-014 Port upd_target_i  in  XLEN  resolved target.
REQ-015 Port upd_taken_i  in  1  resolved direction.

Function
REQ-016 Each entry SHALL hold valid, tag (full XLEN PC), target (XLEN) and a CNT_W-bit counter.
REQ-017 Lookup latency SHALL be exactly 1 cycle: lkp_*_o are registered from the state present in the cycle lkp_v_i=1.
REQ-018 lkp_v_o SHALL equal lkp_v_i delayed one cycle; when lkp_v_o=0, hit, taken and target outputs SHALL be 0.
REQ-019 lkp_taken_o SHALL be the counter MSB of the hit entry, and 0 on a miss; lkp_target_o SHALL be 0 on a miss.
REQ-020 Hits SHALL be one-hot: at most one valid entry matches any PC.
REQ-021 Update hit: counter +1 if upd_taken_i, -1 otherwise, saturating at 2^CNT_W-1 and 0; target overwritten only if upd_taken_i.
REQ-022 Update miss with upd_taken_i=1: allocate an entry (valid=1, tag, target) with counter set to weakly-taken 2^(CNT_W-1).
REQ-023 Update miss with upd_taken_i=0: no state change.
REQ-024 Allocation victim SHALL be the lowest-index invalid entry; if all entries are valid, the entry at round-robin pointer rr_q.
REQ-025 rr_q SHALL advance by 1 only when it selects the victim, wrapping from ENTRIES-1 to 0.
REQ-026 Same-cycle lookup and update of the same PC: the lookup SHALL return pre-update state, with no bypass.
REQ-027 flush_i=1 SHALL clear all valid bits and rr_q, drop that cycle's update, and force lkp_v_o=0 in the next cycle.
REQ-028 Counters and targets of invalid entries are don't-care and SHALL never drive outputs.

Reset
REQ-029 reset_n=0 at a clock edge SHALL clear all valid bits, rr_q, lkp_v_o, lkp_hit_o, lkp_taken_o and lkp_target_o to 0.
REQ-030 Reset asserted mid-operation SHALL discard any in-flight lookup result and update; tags, targets and counters need no reset.

Structure
REQ-031 XLEN SHALL come from riscv_pkg; a btb_entry_t typedef (valid, tag, target, cnt) SHALL be added to riscv_pkg, with CNT_W fixed at the package default.
REQ-032 Sub-module bpred_sat_cnt (parametrised CNT_W; inc/dec/init inputs; next-value output) SHALL implement REQ-021/022 and be instantiated once per entry.
REQ-033 The RTL SHALL elaborate for ENTRIES in {2,4,8,16} and CNT_W in {2,3}.

Verification
REQ-034 Reset, then lookup of 0x100 -> next cycle lkp_v_o=1, lkp_hit_o=0, lkp_taken_o=0, lkp_target_o=0.
REQ-035 Update 0x100 taken to target 0x200, then lookup of 0x100 -> hit=1, taken=1, target=0x200.
REQ-036 CNT_W=2, four not-taken updates of 0x100 -> counter 0, taken=0; five taken updates -> counter saturates at 3.
REQ-037 ENTRIES=4: fill with 0x10/0x20/0x30/0x40, then allocate 0x50 and 0x60 -> evict entries 0 and 1; lookups of 0x10 and 0x20 miss, rr_q=2.
REQ-038 Same-cycle lookup and not-taken update of 0x100 (counter 2) -> lookup reports taken=1; following lookup reports taken=0.
REQ-039 flush_i together with a taken update of 0x300 -> all subsequent lookups miss, including 0x300.
